// File: rtl/syn_pkg.sv
// Shared types and Q16.16 helpers for the synaptic integrator.
package syn_pkg;

   localparam int unsigned Q_W       = 32;
   localparam int unsigned FRAC_BITS = 16;

   localparam logic [Q_W-1:0] Q_MAX = 32'h7FFF_FFFF;
   localparam logic [Q_W-1:0] Q_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_DECAY   = 2'd0,
      S_SCAN    = 2'd1,
      S_PUBLISH = 2'd2
   } state_e;

   // Signed add at Q_W+1 bits, clamped to the Q16.16 range.
   function automatic logic [Q_W-1:0] sat_add(input logic [Q_W-1:0] a,
                                              input logic [Q_W-1:0] b);
      logic [Q_W:0] s;
      s = {a[Q_W-1], a} + {b[Q_W-1], b};
      if (s[Q_W] != s[Q_W-1]) begin
         sat_add = s[Q_W] ? Q_MIN : Q_MAX;
      end else begin
         sat_add = s[Q_W-1:0];
      end
   endfunction

endpackage

// File: rtl/synaptic_integrator_spike_capture.sv
// Per-line rising-edge detect with a sticky pending flag and merge detection.
module spike_capture #(
   parameter int unsigned M = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [M-1:0] synin,
   input  logic [M-1:0] clr_c,
   output logic [M-1:0] pending,
   output logic [M-1:0] drop_c
);

   logic [M-1:0] synin_d_q, synin_d_d;
   logic [M-1:0] pending_q, pending_d;
   logic [M-1:0] rise_c;

   // A new edge wins over a same-cycle clear; an edge onto an uncleared flag is a merge.
   always_comb begin
      synin_d_d = synin;
      rise_c    = synin & ~synin_d_q;
      pending_d = (pending_q & ~clr_c) | rise_c;
      drop_c    = rise_c & pending_q & ~clr_c;
   end

   // Delay line resets high so a line already asserted at release is not a spike.
   always_ff @(posedge clk) begin
      if (!reset) begin
         synin_d_q <= '1;
         pending_q <= '0;
      end else begin
         synin_d_q <= synin_d_d;
         pending_q <= pending_d;
      end
   end

   assign pending = pending_q;

endmodule

// File: rtl/synaptic_integrator.sv
// Synaptic current integrator: decay, per-spike weight accumulation, publish.
// Build option: define SYN_DECAY_EN for a leaky current (acc -= acc >>> TAU_SHIFT
// each period); otherwise each period starts from zero.
module synaptic_integrator
   import syn_pkg::*;
#(
   parameter int unsigned N         = 32,
   parameter int unsigned M         = 8,
   parameter int unsigned TAU_SHIFT = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [M-1:0]         synin,
   input  logic                 w_wr_en,
   input  logic [$clog2(M)-1:0] w_wr_addr,
   input  logic [N-1:0]         w_wr_data,
   output logic [N-1:0]         I,
   output logic                 i_valid,
   output logic [7:0]           drop_cnt
);

   localparam int unsigned AW = $clog2(M);

   // Elaboration guard for unsupported parameter sets.
   if (N != Q_W || M < 2 || TAU_SHIFT >= N || FRAC_BITS >= N) begin : g_param_check
      $error("synaptic_integrator: unsupported parameter set");
   end

   state_e        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [N-1:0]  i_q, i_d;
   logic          i_valid_q, i_valid_d;
   logic [7:0]    drop_cnt_q, drop_cnt_d;
   logic [N-1:0]  w_q [M];
   logic [N-1:0]  w_d [M];

   logic [M-1:0]  pending;
   logic [M-1:0]  drop_c;
   logic [M-1:0]  clr_c;
   logic [N-1:0]  decay_c;

   spike_capture #(.M(M)) u_capture (
      .clk     (clk),
      .reset   (reset),
      .synin   (synin),
      .clr_c   (clr_c),
      .pending (pending),
      .drop_c  (drop_c)
   );

   // Start-of-period value of the accumulator.
`ifdef SYN_DECAY_EN
   always_comb begin
      decay_c = acc_q - N'($signed(acc_q) >>> TAU_SHIFT);
   end
`else
   always_comb begin
      decay_c = '0;
   end
`endif

   // Weight register file; a SCAN read in the write cycle sees the old value.
   always_comb begin
      for (int k = 0; k < M; k++) begin
         w_d[k] = w_q[k];
         if (w_wr_en && w_wr_addr == AW'(k)) begin
            w_d[k] = w_wr_data;
         end
      end
   end

   // Saturating count of merged spikes (several lines may merge in one cycle).
   always_comb begin
      int unsigned cnt;
      int unsigned sum;
      cnt = 0;
      for (int k = 0; k < M; k++) begin
         cnt = cnt + 32'(drop_c[k]);
      end
      sum = 32'(drop_cnt_q) + cnt;
      drop_cnt_d = (sum > 32'd255) ? 8'hFF : 8'(sum);
   end

   // Period sequencer: DECAY, SCAN over every line, PUBLISH.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      i_d       = i_q;
      i_valid_d = 1'b0;
      clr_c     = '0;
      case (state_q)
         S_DECAY: begin
            acc_d   = decay_c;
            idx_d   = '0;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            if (pending[idx_q]) begin
               acc_d        = sat_add(acc_q, w_q[idx_q]);
               clr_c[idx_q] = 1'b1;
            end
            if (idx_q == AW'(M - 1)) begin
               idx_d   = '0;
               state_d = S_PUBLISH;
            end else begin
               idx_d = idx_q + AW'(1);
            end
         end
         S_PUBLISH: begin
            i_d       = acc_q;
            i_valid_d = 1'b1;
            state_d   = S_DECAY;
         end
         default: begin
            state_d = S_DECAY;
            idx_d   = '0;
         end
      endcase
   end

   // State, accumulator, weights and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_DECAY;
         idx_q      <= '0;
         acc_q      <= '0;
         i_q        <= '0;
         i_valid_q  <= 1'b0;
         drop_cnt_q <= '0;
         for (int k = 0; k < M; k++) begin
            w_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         i_q        <= i_d;
         i_valid_q  <= i_valid_d;
         drop_cnt_q <= drop_cnt_d;
         for (int k = 0; k < M; k++) begin
            w_q[k] <= w_d[k];
         end
      end
   end

   assign I        = i_q;
   assign i_valid  = i_valid_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_synaptic_integrator.sv
// Directed bench for synaptic_integrator; expectations follow SYN_DECAY_EN.
module tb_synaptic_integrator;

   localparam int unsigned N   = 32;
   localparam int unsigned M   = 8;
   localparam int unsigned AW  = 3;
   localparam int unsigned PER = M + 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [M-1:0]  synin;
   logic          w_wr_en;
   logic [AW-1:0] w_wr_addr;
   logic [N-1:0]  w_wr_data;
   logic [N-1:0]  i_out;
   logic          i_valid;
   logic [7:0]    drop_cnt;

   int n_vec = 0;
   int n_bad = 0;

   synaptic_integrator #(.N(N), .M(M), .TAU_SHIFT(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .synin     (synin),
      .w_wr_en   (w_wr_en),
      .w_wr_addr (w_wr_addr),
      .w_wr_data (w_wr_data),
      .I         (i_out),
      .i_valid   (i_valid),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b0;
      synin   = '0;
      w_wr_en = 1'b0;
      tick(3);
      reset = 1'b1;
   endtask

   task automatic write_w(input logic [AW-1:0] addr, input logic [N-1:0] data);
      w_wr_en   = 1'b1;
      w_wr_addr = addr;
      w_wr_data = data;
      tick(1);
      w_wr_en = 1'b0;
   endtask

   // Advance to the next i_valid, bounded by a few periods.
   task automatic wait_valid(input string tag);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 3 * PER; c++) begin
         @(negedge clk);
         if (i_valid) begin
            ok = 1'b1;
            break;
         end
      end
      check({tag, "_arrive"}, 32'(ok), 32'd1);
   endtask

   task automatic pulse(input logic [M-1:0] mask, input int n);
      synin = mask;
      tick(n);
      synin = '0;
   endtask

   // Count cycles from reset release to the first i_valid.
   task automatic first_valid(input string tag);
      int first;
      first = 0;
      for (int c = 1; c <= 3 * PER; c++) begin
         @(negedge clk);
         if (i_valid) begin
            first = c;
            break;
         end
      end
      check({tag, "_cycle"}, 32'(first), 32'(PER));
      check({tag, "_i"}, i_out, 32'h0);
   endtask

   initial begin
      logic [31:0] exp_t1_next, exp_t3_next, exp_t4_next, exp_t4b_next;
`ifdef SYN_DECAY_EN
      exp_t1_next  = 32'h0001_E000;
      exp_t3_next  = 32'hFFFF_1000;
      exp_t4_next  = 32'h0000_F000;
      exp_t4b_next = 32'h0001_F000;
`else
      exp_t1_next  = 32'h0000_0000;
      exp_t3_next  = 32'h0000_0000;
      exp_t4_next  = 32'h0000_0000;
      exp_t4b_next = 32'h0001_0000;
`endif
      reset     = 1'b0;
      synin     = '0;
      w_wr_en   = 1'b0;
      w_wr_addr = '0;
      w_wr_data = '0;

      // reset values and first publish timing
      tick(3);
      check("rst_i", i_out, 32'h0);
      check("rst_valid", 32'(i_valid), 32'h0);
      check("rst_drop", 32'(drop_cnt), 32'h0);
      reset = 1'b1;
      first_valid("first");

      // single excitatory spike, then one period with no spikes
      do_reset();
      write_w(3'd3, 32'h0002_0000);
      wait_valid("t1_sync");
      pulse(8'h08, 8);
      wait_valid("t1");
      check("t1_i", i_out, 32'h0002_0000);
      tick(1);
      check("t1_valid_width", 32'(i_valid), 32'h0);
      tick(3);
      check("t1_hold", i_out, 32'h0002_0000);
      wait_valid("t1_next");
      check("t1_next_i", i_out, exp_t1_next);

      // positive and negative saturation
      do_reset();
      write_w(3'd0, 32'h7FFF_0000);
      write_w(3'd1, 32'h7FFF_0000);
      wait_valid("t2_sync");
      pulse(8'h03, 2);
      wait_valid("t2_pos");
      check("t2_pos_i", i_out, 32'h7FFF_FFFF);
      write_w(3'd0, 32'h8000_0000);
      write_w(3'd1, 32'h8000_0000);
      wait_valid("t2_sync2");
      pulse(8'h03, 2);
      wait_valid("t2_neg");
      check("t2_neg_i", i_out, 32'h8000_0000);
      check("t2_drop", 32'(drop_cnt), 32'h0);

      // inhibitory weight
      do_reset();
      write_w(3'd2, 32'hFFFF_0000);
      wait_valid("t3_sync");
      pulse(8'h04, 1);
      wait_valid("t3");
      check("t3_i", i_out, 32'hFFFF_0000);
      wait_valid("t3_next");
      check("t3_next_i", i_out, exp_t3_next);

      // two edges before the scan reaches line 5 merge into one spike
      do_reset();
      write_w(3'd5, 32'h0001_0000);
      wait_valid("t4_sync");
      pulse(8'h20, 1);
      tick(1);
      pulse(8'h20, 1);
      wait_valid("t4");
      check("t4_i", i_out, 32'h0001_0000);
      check("t4_drop", 32'(drop_cnt), 32'h1);
      wait_valid("t4_next");
      check("t4_next_i", i_out, exp_t4_next);

      // edge coincident with the clear is carried to the next period, no drop
      do_reset();
      write_w(3'd5, 32'h0001_0000);
      wait_valid("t4b_sync");
      pulse(8'h20, 1);
      tick(5);
      pulse(8'h20, 1);
      wait_valid("t4b");
      check("t4b_i", i_out, 32'h0001_0000);
      check("t4b_drop", 32'(drop_cnt), 32'h0);
      wait_valid("t4b_next");
      check("t4b_next_i", i_out, exp_t4b_next);

      // reset mid-scan with a nonzero partial sum
      do_reset();
      write_w(3'd3, 32'h0002_0000);
      wait_valid("t5_sync");
      pulse(8'h08, 2);
      wait_valid("t5");
      check("t5_i", i_out, 32'h0002_0000);
      pulse(8'h08, 1);
      tick(5);
      reset = 1'b0;
      tick(1);
      check("t5_rst_i", i_out, 32'h0);
      check("t5_rst_valid", 32'(i_valid), 32'h0);
      tick(2);
      reset = 1'b1;
      first_valid("t5_first");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/synaptic_integrator.md
# synaptic_integrator

Upstream stage of the spiking neuron: converts presynaptic impulse lines into the signed Q16.16 synaptic current `I` that the neuron integrates every clock. Each presynaptic line is edge-detected and latched as a pending spike. A fixed-period sequencer decays the running current, adds one programmable weight per pending spike, and publishes the result as a stable register. Inhibitory synapses use negative weights.

## Interface
- `N`, 32: data width; signed Q16.16 (FRAC_BITS = 16).
- `M`, 8: number of presynaptic lines; must be ≥ 2.
- `TAU_SHIFT`, 4: decay shift; per-period decay is `acc - (acc >>> TAU_SHIFT)`.
- `clk`  input  1: single clock; all state on rising edge.
- `reset`  input  1: synchronous, active-low reset.
- `synin`  input  M: presynaptic impulse lines; each spike is a high pulse of ≥ 1 cycle (neuron impulse output).
- `w_wr_en`  input  1: weight write strobe.
- `w_wr_addr`  input  $clog2(M): synapse index.
- `w_wr_data`  input  N: signed Q16.16 weight.
- `I`  output  N: signed Q16.16 synaptic current; drives the neuron `I` input.
- `i_valid`  output  1: one-cycle pulse when `I` is updated.
- `drop_cnt`  output  8: saturating count of merged (lost) spikes.

## Operation
- Edge detect per line: `edge[k] = synin[k] & ~synin_d[k]`; `synin_d` resets to all ones, so a line already high at reset release does not count as a spike.
- `pending[k]` is set on `edge[k]`. If `edge[k]` arrives while `pending[k]` is already set, the spike is merged and `drop_cnt` increments, saturating at 255.
- FSM states DECAY → SCAN → PUBLISH → DECAY. Period is M+2 cycles.
- DECAY (1 cycle): `acc <= acc - (acc >>> TAU_SHIFT)`, using an arithmetic shift.
- SCAN (M cycles, `idx` 0..M-1): if `pending[idx]`, then `acc <= sat(acc + w[idx])` and `pending[idx]` is cleared.
  - If `edge[idx]` occurs in the same cycle as its clear, the pending bit stays set; the new spike counts next period and is not a drop.
- PUBLISH (1 cycle): `I <= acc`; `i_valid` pulses high.
- Saturation: the addition is computed at N+1 bits and clamped to 0x7FFF_FFFF / 0x8000_0000. Decay never overflows.
- Weights: M×N register array. A write takes effect the cycle after `w_wr_en`. A SCAN read of the address being written in that cycle uses the old value.
- Reset values:
  - `I` = 0, `i_valid` = 0, `drop_cnt` = 0.
  - `acc` = 0, `pending` = 0, all weights = 0.
  - State = DECAY, `idx` = 0.
- Reset asserted mid-SCAN discards the partial sum; the next period starts from `acc` = 0.

## Timing
- Spike edge at cycle t with `pending` captured at t+1. It is added in the current period if SCAN reaches its index at or after t+1; otherwise it is added in the next period.
- Worst-case latency from edge to `I` reflecting it: 2·(M+2) cycles.
- `I` holds constant between PUBLISH cycles. `i_valid` is high exactly 1 cycle in every M+2.
- First `i_valid` after reset release: cycle M+2 (reset-release cycle = 1).

## Configuration
- `SYN_DECAY_EN` defined: DECAY performs the shift-decay above (leaky current).
- Undefined: DECAY loads `acc <= 0`, so `I` is the plain sum of weights of spikes captured in that period. The period length is unchanged, and `TAU_SHIFT` is ignored.

## Structure
- Package `syn_pkg`: FSM state enum (`S_DECAY`, `S_SCAN`, `S_PUBLISH`), `FRAC_BITS`, `Q_MAX`, `Q_MIN`, and the `sat_add` function.
- Sub-module `spike_capture`: per-line delay register, edge detect, pending flag, and clear/merge logic. It is instantiated once with width M and outputs `pending` and `drop` pulses.

## Test plan
- After reset: w[3] = 0x0002_0000; pulse `synin[3]` high for 8 cycles → next `i_valid` gives `I` = 0x0002_0000. The following period (no spikes) gives `I` = 0x0001_E000.
- w[0] = 0x7FFF_0000, w[1] = 0x7FFF_0000; spike both lines → `I` = 0x7FFF_FFFF (saturated). Repeat with w = 0x8000_0000 → `I` = 0x8000_0000.
- Inhibitory: w[2] = 0xFFFF_0000 (−1.0); spike once from `acc` = 0 → `I` = 0xFFFF_0000. Next period → 0xFFFF_1000.
- Two rising edges on `synin[5]` before SCAN reaches idx 5 → one weight added; `drop_cnt` = 1.
- Assert `reset` low during SCAN with `acc` ≠ 0 → next cycle `I` = 0 and `i_valid` = 0. After release, first `i_valid` at cycle M+2 with `I` = 0.
- Build without `SYN_DECAY_EN`: w[3] = 0x0002_0000, one spike → `I` = 0x0002_0000, then 0x0000_0000 next period.
